// File: rtl/hog_ctrl_pkg.sv
// rtl/hog_ctrl_pkg.sv - shared register map, field layout and FSM states for the HOG sequencer
package hog_ctrl_pkg;

  localparam logic [3:0] REG_CTRL     = 4'h0;
  localparam logic [3:0] REG_STATUS   = 4'h4;
  localparam logic [3:0] REG_CFG      = 4'h8;
  localparam logic [3:0] REG_PROGRESS = 4'hC;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 2;
  localparam int STAT_BUSY_BIT   = 0;
  localparam int STAT_DONE_BIT   = 1;
  localparam int STAT_ERR_BIT    = 2;

  // CFG word layout: PAIRS in [31:16], BEATS in [15:0]
  typedef struct packed {
    logic [15:0] pairs;
    logic [15:0] beats;
  } hog_cfg_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_FIN
  } seq_state_t;

endpackage

// File: rtl/hog_axil_regs.sv
// rtl/hog_axil_regs.sv - AXI4-Lite slave and register file for the HOG sequencer
module hog_axil_regs
  import hog_ctrl_pkg::*;
#(
  parameter int C_S_AXI_GP_DATA_WIDTH = 32,
  parameter int C_S_AXI_GP_ADDR_WIDTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [C_S_AXI_GP_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [2:0]                           s_axi_awprot,
  input  logic                                 s_axi_awvalid,
  output logic                                 s_axi_awready,
  input  logic [C_S_AXI_GP_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_S_AXI_GP_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                                 s_axi_wvalid,
  output logic                                 s_axi_wready,
  output logic [1:0]                           s_axi_bresp,
  output logic                                 s_axi_bvalid,
  input  logic                                 s_axi_bready,
  input  logic [C_S_AXI_GP_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [2:0]                           s_axi_arprot,
  input  logic                                 s_axi_arvalid,
  output logic                                 s_axi_arready,
  output logic [C_S_AXI_GP_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                           s_axi_rresp,
  output logic                                 s_axi_rvalid,
  input  logic                                 s_axi_rready,
  output logic                                 start,
  output hog_cfg_t                             cfg,
  output logic                                 irq_en,
  input  logic                                 busy,
  input  logic                                 set_done,
  input  logic                                 set_err,
  input  logic [15:0]                          progress
);

  logic       aw_w_ready;
  logic       done_q;
  logic       err_q;
  logic       wr_fire;
  logic       rd_fire;
  logic [3:0] wr_off;
  logic [3:0] rd_off;
  logic [C_S_AXI_GP_DATA_WIDTH-1:0] rd_mux;
  logic       unused_bits;

  assign wr_off  = {s_axi_awaddr[3:2], 2'b00};
  assign rd_off  = {s_axi_araddr[3:2], 2'b00};
  assign wr_fire = aw_w_ready && s_axi_awvalid && s_axi_wvalid;
  assign rd_fire = s_axi_arready && s_axi_arvalid;

  assign s_axi_awready = aw_w_ready;
  assign s_axi_wready  = aw_w_ready;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_rresp   = 2'b00;

  // Combinational so the FSM can leave IDLE on the handshake edge itself
  assign start = wr_fire && (wr_off == REG_CTRL) && s_axi_wdata[CTRL_START_BIT];

  assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_wstrb,
                         s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  always_comb begin
    rd_mux = '0;
    case (rd_off)
      REG_CTRL:     rd_mux[CTRL_IRQ_EN_BIT] = irq_en;
      REG_STATUS: begin
        rd_mux[STAT_BUSY_BIT] = busy;
        rd_mux[STAT_DONE_BIT] = done_q;
        rd_mux[STAT_ERR_BIT]  = err_q;
      end
      REG_CFG:      rd_mux = cfg;
      REG_PROGRESS: rd_mux[15:0] = progress;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_w_ready    <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      cfg           <= '0;
      irq_en        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      aw_w_ready    <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !aw_w_ready;
      s_axi_arready <= s_axi_arvalid && !s_axi_rvalid && !s_axi_arready;

      if (wr_fire)
        s_axi_bvalid <= 1'b1;
      else if (s_axi_bready)
        s_axi_bvalid <= 1'b0;

      if (rd_fire) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_mux;
      end else if (s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end

      if (wr_fire && wr_off == REG_CTRL)
        irq_en <= s_axi_wdata[CTRL_IRQ_EN_BIT];
      if (wr_fire && wr_off == REG_CFG && !busy)
        cfg <= hog_cfg_t'(s_axi_wdata);

      // Hardware set wins over a simultaneous software clear
      if (set_done)
        done_q <= 1'b1;
      else if (wr_fire && wr_off == REG_STATUS && s_axi_wdata[STAT_DONE_BIT])
        done_q <= 1'b0;
      if (set_err)
        err_q <= 1'b1;
      else if (wr_fire && wr_off == REG_STATUS && s_axi_wdata[STAT_ERR_BIT])
        err_q <= 1'b0;
    end
  end

endmodule

// File: rtl/hog_seq_ctrl.sv
// rtl/hog_seq_ctrl.sv - row-pair frame sequencer: input gating, output TLAST and completion irq
module hog_seq_ctrl
  import hog_ctrl_pkg::*;
#(
  parameter int C_S_AXI_GP_DATA_WIDTH = 32,
  parameter int C_S_AXI_GP_ADDR_WIDTH = 4,
  parameter int CNT_W                 = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [C_S_AXI_GP_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [2:0]                           s_axi_awprot,
  input  logic                                 s_axi_awvalid,
  output logic                                 s_axi_awready,
  input  logic [C_S_AXI_GP_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_S_AXI_GP_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                                 s_axi_wvalid,
  output logic                                 s_axi_wready,
  output logic [1:0]                           s_axi_bresp,
  output logic                                 s_axi_bvalid,
  input  logic                                 s_axi_bready,
  input  logic [C_S_AXI_GP_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [2:0]                           s_axi_arprot,
  input  logic                                 s_axi_arvalid,
  output logic                                 s_axi_arready,
  output logic [C_S_AXI_GP_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                           s_axi_rresp,
  output logic                                 s_axi_rvalid,
  input  logic                                 s_axi_rready,
  input  logic                                 s_hs0,
  input  logic                                 s_hs1,
  input  logic                                 m_hs0,
  input  logic                                 m_hs1,
  output logic                                 in_en0,
  output logic                                 in_en1,
  output logic                                 m_tlast0,
  output logic                                 m_tlast1,
  output logic                                 core_start,
  output logic                                 irq
);

  seq_state_t state, state_nxt;
  hog_cfg_t   cfg;
  logic       start, irq_en, set_done, set_err, busy, run, cfg_ok, pair_done;
  logic       in_inc0, in_inc1, out_inc0, out_inc1, ovr0, ovr1;
  logic [CNT_W-1:0] beats, pairs, prog_nxt;
  logic [CNT_W-1:0] in_cnt0, in_cnt1, out_cnt0, out_cnt1, progress;
  logic [CNT_W-1:0] out_nxt0, out_nxt1;
  logic [15:0]      progress16;

  hog_axil_regs #(
    .C_S_AXI_GP_DATA_WIDTH(C_S_AXI_GP_DATA_WIDTH),
    .C_S_AXI_GP_ADDR_WIDTH(C_S_AXI_GP_ADDR_WIDTH)
  ) u_regs (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .start(start), .cfg(cfg), .irq_en(irq_en),
    .busy(busy), .set_done(set_done), .set_err(set_err), .progress(progress16)
  );

  assign beats      = CNT_W'(cfg.beats);
  assign pairs      = CNT_W'(cfg.pairs);
  assign progress16 = 16'(progress);
  assign cfg_ok     = (beats != '0) && (pairs != '0);
  assign busy       = (state != ST_IDLE);
  assign run        = (state == ST_RUN);

  assign in_inc0  = run && s_hs0 && (in_cnt0 != beats);
  assign in_inc1  = run && s_hs1 && (in_cnt1 != beats);
  assign out_inc0 = run && m_hs0 && (out_cnt0 != beats);
  assign out_inc1 = run && m_hs1 && (out_cnt1 != beats);
  assign ovr0     = run && m_hs0 && (out_cnt0 == beats);
  assign ovr1     = run && m_hs1 && (out_cnt1 == beats);
  assign out_nxt0 = out_cnt0 + CNT_W'(out_inc0);
  assign out_nxt1 = out_cnt1 + CNT_W'(out_inc1);
  // Judged on post-increment counts so same-cycle final beats close the pair at once
  assign pair_done = run && (out_nxt0 == beats) && (out_nxt1 == beats);
  assign prog_nxt  = progress + 1'b1;

  assign in_en0   = run && (in_cnt0 != beats);
  assign in_en1   = run && (in_cnt1 != beats);
  assign m_tlast0 = run && (out_cnt0 == beats - 1'b1);
  assign m_tlast1 = run && (out_cnt1 == beats - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    core_start = 1'b0;
    irq        = 1'b0;
    set_done   = 1'b0;
    set_err    = ovr0 || ovr1;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (cfg_ok) state_nxt = ST_ARM;
          else        set_err   = 1'b1;
        end
      end
      ST_ARM: begin
        core_start = 1'b1;
        state_nxt  = ST_RUN;
      end
      ST_RUN: begin
        if (pair_done && prog_nxt == pairs) state_nxt = ST_FIN;
      end
      ST_FIN: begin
        set_done  = 1'b1;
        irq       = irq_en;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt0  <= '0;
      in_cnt1  <= '0;
      out_cnt0 <= '0;
      out_cnt1 <= '0;
      progress <= '0;
    end else if (state == ST_ARM) begin
      in_cnt0  <= '0;
      in_cnt1  <= '0;
      out_cnt0 <= '0;
      out_cnt1 <= '0;
      progress <= '0;
    end else if (pair_done) begin
      in_cnt0  <= '0;
      in_cnt1  <= '0;
      out_cnt0 <= '0;
      out_cnt1 <= '0;
      progress <= prog_nxt;
    end else begin
      in_cnt0  <= in_cnt0 + CNT_W'(in_inc0);
      in_cnt1  <= in_cnt1 + CNT_W'(in_inc1);
      out_cnt0 <= out_nxt0;
      out_cnt1 <= out_nxt1;
    end
  end

endmodule

// File: tb/tb_hog_seq_ctrl.sv
// tb/tb_hog_seq_ctrl.sv - self-checking bench for hog_seq_ctrl
module tb_hog_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  s_axi_awaddr = '0, s_axi_araddr = '0;
  logic [2:0]  s_axi_awprot = '0, s_axi_arprot = '0;
  logic        s_axi_awvalid = 0, s_axi_wvalid = 0, s_axi_bready = 1, s_axi_arvalid = 0, s_axi_rready = 1;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = 4'hF;
  logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic [31:0] s_axi_rdata;
  logic        s_hs0 = 0, s_hs1 = 0, m_hs0 = 0, m_hs1 = 0;
  logic        in_en0, in_en1, m_tlast0, m_tlast1, core_start, irq;

  hog_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_hs0(s_hs0), .s_hs1(s_hs1), .m_hs0(m_hs0), .m_hs1(m_hs1),
    .in_en0(in_en0), .in_en1(in_en1), .m_tlast0(m_tlast0), .m_tlast1(m_tlast1),
    .core_start(core_start), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] exp;
    string       name;
  } rd_vec_t;

  typedef struct {
    int   port;
    logic exp;
  } tl_exp_t;

  rd_vec_t     tbl[$];
  tl_exp_t     tl_q[$];
  logic [31:0] rd_q[$];

  int checks = 0, errors = 0;
  int cyc = 0, hs_cyc = 0, cs_cyc = -100, cs_cnt = 0, irq_cnt = 0;
  logic smp_in0, smp_in1, smp_irq;

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (core_start) begin cs_cyc = cyc; cs_cnt++; end
    if (irq) irq_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data);
    int n;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_awvalid = 1; s_axi_wvalid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_axi_awready && n < 20);
    chk("aw_handshake", {31'b0, s_axi_awready}, 1);
    hs_cyc = cyc;
    @(posedge clk); #1;
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_axi_bvalid && n < 20);
    chk("bvalid", {31'b0, s_axi_bvalid}, 1);
    chk("bresp", {30'b0, s_axi_bresp}, 0);
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input string name);
    int n;
    logic [31:0] e;
    rd_q.push_back(exp);
    s_axi_araddr = addr; s_axi_arvalid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_axi_arready && n < 20);
    chk("ar_handshake", {31'b0, s_axi_arready}, 1);
    @(posedge clk); #1;
    s_axi_arvalid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_axi_rvalid && n < 20);
    chk("rvalid", {31'b0, s_axi_rvalid}, 1);
    e = rd_q.pop_front();
    chk(name, s_axi_rdata, e);
    chk("rresp", {30'b0, s_axi_rresp}, 0);
    @(posedge clk); #1;
  endtask

  task automatic apply_tbl(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) axi_read(tbl[i].addr, tbl[i].exp, tbl[i].name);
  endtask

  // One clock of stream handshakes; TLAST expectations are queued at drive time
  task automatic step(input logic s0, input logic s1, input logic m0, input logic m1,
                      input logic t0, input logic t1);
    tl_exp_t e;
    if (m0) tl_q.push_back('{0, t0});
    if (m1) tl_q.push_back('{1, t1});
    s_hs0 = s0; s_hs1 = s1; m_hs0 = m0; m_hs1 = m1;
    @(negedge clk);
    smp_in0 = in_en0; smp_in1 = in_en1; smp_irq = irq;
    while (tl_q.size() > 0) begin
      e = tl_q.pop_front();
      if (e.port == 0) chk("m_tlast0", {31'b0, m_tlast0}, {31'b0, e.exp});
      else             chk("m_tlast1", {31'b0, m_tlast1}, {31'b0, e.exp});
    end
    @(posedge clk); #1;
    s_hs0 = 0; s_hs1 = 0; m_hs0 = 0; m_hs1 = 0;
  endtask

  task automatic pair(input int beats, input int extra0, input int skew,
                      input bit ovr, input bit last, input bit irq_exp);
    logic m0, m1;
    for (int k = 0; k < beats + extra0; k++) begin
      step(1'b1, k < beats, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("in_en0", {31'b0, smp_in0}, {31'b0, k < beats});
      chk("in_en1", {31'b0, smp_in1}, {31'b0, k < beats});
    end
    for (int k = 0; k < beats + skew; k++) begin
      m0 = (k < beats) || (ovr && k == beats);
      m1 = (k >= skew) && (k < skew + beats);
      step(1'b0, 1'b0, m0, m1, k == beats - 1, (k - skew) == beats - 1);
      chk("in_en_held", {30'b0, smp_in0, smp_in1}, 0);
    end
    step(0, 0, 0, 0, 0, 0);
    if (last) begin
      chk("irq_fin", {31'b0, smp_irq}, {31'b0, irq_exp});
      chk("in_en_fin", {30'b0, smp_in0, smp_in1}, 0);
      step(0, 0, 0, 0, 0, 0);
    end else begin
      chk("in_en_resume", {30'b0, smp_in0, smp_in1}, 2'b11);
    end
  endtask

  task automatic frame(input int beats, input int pairs, input int skew, input bit irq_exp);
    for (int p = 0; p < pairs; p++) pair(beats, 0, skew, 1'b0, p == pairs - 1, irq_exp);
  endtask

  function automatic logic [31:0] outs();
    return {21'b0, in_en0, in_en1, m_tlast0, m_tlast1, core_start, irq,
            s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    tbl.push_back('{4'h0, 32'h0, "rst_ctrl"});
    tbl.push_back('{4'h4, 32'h0, "rst_status"});
    tbl.push_back('{4'h8, 32'h0, "rst_cfg"});
    tbl.push_back('{4'hC, 32'h0, "rst_progress"});
    tbl.push_back('{4'hC, 32'h2, "f1_progress"});
    tbl.push_back('{4'h4, 32'h2, "f1_status"});
    tbl.push_back('{4'h0, 32'h4, "f1_ctrl"});
    tbl.push_back('{4'h8, 32'h0002_0004, "f1_cfg"});

    repeat (3) @(posedge clk);
    chk("outputs_in_reset", outs(), 0);
    #1 rst = 0;
    @(posedge clk); #1;
    chk("outputs_after_reset", outs(), 0);
    apply_tbl(0, 3);

    // Basic frame: 4 beats/row, 2 pairs, back-to-back, irq enabled
    axi_write(4'h8, 32'h0002_0004);
    axi_write(4'h0, 32'h5);
    chk("core_start_t1", cs_cyc, hs_cyc + 1);
    frame(4, 2, 0, 1'b1);
    apply_tbl(4, 7);
    chk("irq_count_f1", irq_cnt, 1);

    // Input overrun on HP0: 5 handshakes offered, only 3 accepted
    axi_write(4'h4, 32'h6);
    axi_write(4'h8, 32'h0002_0003);
    axi_write(4'h0, 32'h5);
    pair(3, 2, 0, 1'b0, 1'b0, 1'b1);
    pair(3, 0, 0, 1'b0, 1'b1, 1'b1);
    axi_read(4'hC, 32'h2, "f2_progress");
    chk("irq_count_f2", irq_cnt, 2);

    // Skewed HP1 output then same-cycle final beats
    axi_write(4'h4, 32'h6);
    axi_write(4'h8, 32'h0002_0002);
    axi_write(4'h0, 32'h5);
    pair(2, 0, 10, 1'b0, 1'b0, 1'b1);
    pair(2, 0, 0, 1'b0, 1'b1, 1'b1);
    axi_read(4'h4, 32'h2, "f3_status");
    chk("irq_count_f3", irq_cnt, 3);

    // Zero PAIRS field: ERR, no frame started
    axi_write(4'h4, 32'h6);
    axi_write(4'h8, 32'h0000_0004);
    n = cs_cnt;
    axi_write(4'h0, 32'h1);
    repeat (2) step(0, 0, 0, 0, 0, 0);
    chk("no_core_start_on_err", cs_cnt, n);
    axi_read(4'h4, 32'h4, "err_status");
    axi_write(4'h4, 32'h4);
    axi_read(4'h4, 32'h0, "err_cleared");

    // Extra m_hs0 after the row's last beat sets ERR; irq disabled
    axi_write(4'h8, 32'h0001_0002);
    axi_write(4'h0, 32'h1);
    pair(2, 0, 4, 1'b1, 1'b1, 1'b0);
    axi_read(4'h4, 32'h6, "ovr_status");
    chk("irq_count_ovr", irq_cnt, 3);

    // Asynchronous reset mid-RUN with PROGRESS=1
    axi_write(4'h4, 32'h6);
    axi_write(4'h8, 32'h0002_0002);
    axi_write(4'h0, 32'h5);
    pair(2, 0, 0, 1'b0, 1'b0, 1'b1);
    axi_read(4'hC, 32'h1, "mid_progress");
    step(1, 1, 0, 0, 0, 0);
    s_hs0 = 1;
    #3 rst = 1;
    #1 chk("outputs_async_reset", outs(), 0);
    @(posedge clk); #1;
    rst = 0; s_hs0 = 0;
    step(0, 0, 0, 0, 0, 0);
    chk("irq_count_rst", irq_cnt, 3);
    axi_read(4'h4, 32'h0, "rst2_status");
    axi_read(4'hC, 32'h0, "rst2_progress");

    axi_write(4'h8, 32'h0002_0003);
    axi_write(4'h0, 32'h5);
    chk("core_start_t1_rerun", cs_cyc, hs_cyc + 1);
    frame(3, 2, 0, 1'b1);
    axi_read(4'hC, 32'h2, "rerun_progress");
    axi_read(4'h4, 32'h2, "rerun_status");
    chk("irq_count_rerun", irq_cnt, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
